// File: rtl/raw_to_bcd_scan_if.sv
// Handshake and data bundle for raw_to_bcd_scan: the requester drives start/data_raw,
// the converter returns packed BCD results with busy/done status.
interface raw_to_bcd_scan_if #(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned W      = 16,
    parameter int unsigned DIGITS = 5
);
    logic                         start;
    logic [NUM_CH*W-1:0]          data_raw;
    logic [NUM_CH*DIGITS*4-1:0]   bcd_out;
    logic                         busy;
    logic                         done;

    modport master (
        output start,
        output data_raw,
        input  bcd_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data_raw,
        output bcd_out,
        output busy,
        output done
    );
endinterface

// File: rtl/raw_to_bcd_scan.sv
// Sequential binary-to-BCD converter: snapshots NUM_CH packed counters and converts them one
// at a time with double dabble, publishing all channels atomically with a one-cycle done pulse.
module raw_to_bcd_scan #(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned W      = 16,
    parameter int unsigned DIGITS = 5
) (
    input logic               clk,
    input logic               reset,
    raw_to_bcd_scan_if.slave  bus_io
);

    localparam int unsigned BcdW  = DIGITS * 4;
    localparam int unsigned SregW = BcdW + W;
    localparam int unsigned RawW  = NUM_CH * W;
    localparam int unsigned OutW  = NUM_CH * BcdW;
    localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IterW = (W > 1) ? $clog2(W) : 1;

    localparam logic [ChW-1:0]   ChLast   = ChW'(NUM_CH - 1);
    localparam logic [IterW-1:0] IterLast = IterW'(W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StStore,
        StCommit
    } state_e;

    state_e             state_q, state_d;
    logic [ChW-1:0]     ch_q, ch_d;
    logic [IterW-1:0]   iter_q, iter_d;
    logic [RawW-1:0]    shadow_q, shadow_d;
    logic [SregW-1:0]   shift_q, shift_d;
    logic [OutW-1:0]    work_q, work_d;
    logic [OutW-1:0]    bcd_out_q, bcd_out_d;
    logic               done_q, done_d;

    logic [SregW-1:0]   sreg_adj;

    // Double-dabble correction: bias every BCD nibble >= 5 before the doubling shift.
    always_comb begin
        sreg_adj = shift_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (sreg_adj[W + d*4 +: 4] >= 4'd5) begin
                sreg_adj[W + d*4 +: 4] = sreg_adj[W + d*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        iter_d    = iter_q;
        shadow_d  = shadow_q;
        shift_d   = shift_q;
        work_d    = work_q;
        bcd_out_d = bcd_out_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    shadow_d = bus_io.data_raw;
                    ch_d     = '0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                shift_d = {{BcdW{1'b0}}, shadow_q[int'(ch_q)*W +: W]};
                iter_d  = '0;
                state_d = StShift;
            end
            StShift: begin
                shift_d = sreg_adj << 1;
                if (iter_q == IterLast) begin
                    state_d = StStore;
                end else begin
                    iter_d = iter_q + IterW'(1);
                end
            end
            StStore: begin
                work_d[int'(ch_q)*BcdW +: BcdW] = shift_q[W +: BcdW];
                if (ch_q == ChLast) begin
                    state_d = StCommit;
                end else begin
                    ch_d    = ch_q + ChW'(1);
                    state_d = StLoad;
                end
            end
            StCommit: begin
                // Only path to bcd_out, so partial channel results are never visible.
                bcd_out_d = work_q;
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            iter_q    <= '0;
            shadow_q  <= '0;
            shift_q   <= '0;
            work_q    <= '0;
            bcd_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            iter_q    <= iter_d;
            shadow_q  <= shadow_d;
            shift_q   <= shift_d;
            work_q    <= work_d;
            bcd_out_q <= bcd_out_d;
            done_q    <= done_d;
        end
    end

    assign bus_io.bcd_out = bcd_out_q;
    assign bus_io.busy    = (state_q != StIdle);
    assign bus_io.done    = done_q;

endmodule

// File: tb/tb_raw_to_bcd_scan.sv
// Directed self-checking bench for raw_to_bcd_scan with default parameters.
module tb_raw_to_bcd_scan;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned W      = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned OutW   = NUM_CH * DIGITS * 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    raw_to_bcd_scan_if #(.NUM_CH(NUM_CH), .W(W), .DIGITS(DIGITS)) bus ();

    raw_to_bcd_scan #(.NUM_CH(NUM_CH), .W(W), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OutW-1:0] obs, input logic [OutW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference conversion by repeated division by ten.
    function automatic logic [19:0] bcd_of(input int unsigned v);
        logic [19:0]  r;
        int unsigned  x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [OutW-1:0] model(input logic [NUM_CH*W-1:0] raw);
        logic [OutW-1:0] r;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            r[i*20 +: 20] = bcd_of(int'(raw[i*W +: W]));
        end
        return r;
    endfunction

    function automatic logic [OutW-1:0] fill(input logic [19:0] s);
        logic [OutW-1:0] r;
        for (int i = 0; i < int'(NUM_CH); i++) r[i*20 +: 20] = s;
        return r;
    endfunction

    // Called on a falling edge; raises start so the next rising edge is E0. Returns on the
    // falling edge just after E0+289. pulse_*/chg_at name the rising edge (relative to E0)
    // that samples the extra start pulse or the data_raw change.
    task automatic conv(input bit hold, input int pulse_a, input int pulse_b, input int chg_at,
                        input int chg_ch, input logic [W-1:0] chg_val,
                        input logic [OutW-1:0] exp, input string tag);
        logic [OutW-1:0] prev;
        bit              quiet;
        prev  = bus.bcd_out;
        quiet = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        chk({tag, "_busy_after_e0"}, OutW'({bus.busy, bus.done}), OutW'(2'b10));
        for (int e = 1; e <= 288; e++) begin
            if (e == pulse_a || e == pulse_b) bus.start = 1'b1;
            else if (!hold) bus.start = 1'b0;
            if (e == chg_at) bus.data_raw[chg_ch*W +: W] = chg_val;
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.bcd_out !== prev) quiet = 1'b0;
        end
        if (!hold) bus.start = 1'b0;
        chk({tag, "_quiet_while_busy"}, OutW'(quiet), OutW'(1'b1));
        @(negedge clk);
        chk({tag, "_done_at_289"}, OutW'({bus.busy, bus.done}), OutW'(2'b01));
        chk({tag, "_bcd_out"}, bus.bcd_out, exp);
    endtask

    logic [OutW-1:0] exp_v;
    bit              quiet_r;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.data_raw  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy_done", OutW'({bus.busy, bus.done}), '0);
        chk("reset_bcd_out", bus.bcd_out, '0);
        reset = 1'b0;
        @(negedge clk);

        // All-zero input.
        conv(1'b0, -1, -1, -1, 0, '0, '0, "zero");
        @(negedge clk);
        chk("zero_done_one_cycle", OutW'({bus.busy, bus.done}), '0);

        // Boundary values, hand-computed.
        for (int i = 0; i < int'(NUM_CH); i++) bus.data_raw[i*W +: W] = 16'd9;
        bus.data_raw[0*W +: W]  = 16'd65535;
        bus.data_raw[1*W +: W]  = 16'd0;
        bus.data_raw[15*W +: W] = 16'd12345;
        exp_v = fill(20'h00009);
        exp_v[0*20 +: 20]  = 20'h65535;
        exp_v[1*20 +: 20]  = 20'h00000;
        exp_v[15*20 +: 20] = 20'h12345;
        conv(1'b0, -1, -1, -1, 0, '0, exp_v, "bounds");
        chk("bounds_slice0", OutW'(bus.bcd_out[0 +: 20]), OutW'(20'h65535));
        chk("bounds_slice15", OutW'(bus.bcd_out[15*20 +: 20]), OutW'(20'h12345));
        @(negedge clk);

        // data_raw changed mid-conversion must not leak in.
        for (int i = 0; i < int'(NUM_CH); i++) bus.data_raw[i*W +: W] = 16'd7;
        bus.data_raw[3*W +: W] = 16'd100;
        exp_v = fill(20'h00007);
        exp_v[3*20 +: 20] = 20'h00100;
        conv(1'b0, -1, -1, 50, 3, 16'd999, exp_v, "snapshot");
        chk("snapshot_slice3", OutW'(bus.bcd_out[3*20 +: 20]), OutW'(20'h00100));
        @(negedge clk);

        // start pulses while busy are ignored.
        for (int i = 0; i < int'(NUM_CH); i++) bus.data_raw[i*W +: W] = 16'(i * 4321 + 17);
        exp_v = model(bus.data_raw);
        conv(1'b0, 10, 200, -1, 0, '0, exp_v, "ignore_start");
        quiet_r = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) quiet_r = 1'b0;
        end
        chk("ignore_start_no_second_run", OutW'(quiet_r), OutW'(1'b1));

        // Start held high: back-to-back conversions every 290 cycles.
        bus.data_raw = '0;
        for (int i = 0; i < int'(NUM_CH); i++) bus.data_raw[i*W +: W] = 16'd9;
        conv(1'b1, -1, -1, -1, 0, '0, fill(20'h00009), "hold9");
        for (int i = 0; i < int'(NUM_CH); i++) bus.data_raw[i*W +: W] = 16'd10;
        conv(1'b1, -1, -1, -1, 0, '0, fill(20'h00010), "hold10");
        for (int i = 0; i < int'(NUM_CH); i++) bus.data_raw[i*W +: W] = 16'd11;
        conv(1'b1, -1, -1, -1, 0, '0, fill(20'h00011), "hold11");
        bus.start = 1'b0;
        @(negedge clk);
        chk("hold_stop", OutW'({bus.busy, bus.done}), '0);

        // Reset mid-conversion aborts and clears results.
        for (int i = 0; i < int'(NUM_CH); i++) bus.data_raw[i*W +: W] = 16'(i * 997 + 500);
        exp_v = model(bus.data_raw);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy_done", OutW'({bus.busy, bus.done}), '0);
        chk("abort_bcd_out", bus.bcd_out, '0);
        @(negedge clk);
        reset = 1'b0;
        quiet_r = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.bcd_out !== '0) quiet_r = 1'b0;
        end
        chk("abort_no_done", OutW'(quiet_r), OutW'(1'b1));
        conv(1'b0, -1, -1, -1, 0, '0, exp_v, "after_reset");
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/raw_to_bcd_scan.md
RAW_TO_BCD_SCAN -- requirements
Module: raw_to_bcd_scan

Interface
REQ-001 SHALL provide parameter NUM_CH, default 16, number of packed counter channels.
REQ-002 SHALL provide parameter W, default 16, binary width per channel.
REQ-003 SHALL provide parameter DIGITS, default 5, BCD digits per channel; DIGITS*4 bits hold 2^W-1.
REQ-004 SHALL have clk  input  1  system clock (100 MHz); all logic on rising edge.
REQ-005 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have start  input  1  conversion request, sampled only in IDLE.
REQ-007 SHALL have data_raw  input  NUM_CH*W  packed binary values; channel i = data_raw[i*W +: W].
REQ-008 SHALL have bcd_out  output  NUM_CH*DIGITS*4  packed BCD; channel i = bcd_out[i*DIGITS*4 +: DIGITS*4]; digit d (0 = ones) = channel slice [d*4 +: 4].
REQ-009 SHALL have busy  output  1  high while a conversion is in progress.
REQ-010 SHALL have done  output  1  one-cycle pulse, coincident with first cycle bcd_out shows new results.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, SHIFT, STORE, COMMIT.
REQ-012 IDLE: start=1 at edge -> snapshot data_raw into shadow register, ch=0, go LOAD; start=0 -> stay IDLE.
REQ-013 LOAD (1 cycle): shift register <= {DIGITS*4 zeros, shadow channel ch}, iteration count=0, go SHIFT.
REQ-014 SHIFT (W cycles): each cycle, add 3 to every BCD nibble >= 5, then shift whole register left 1 (double dabble); after W-th iteration go STORE.
REQ-015 STORE (1 cycle): BCD part -> work buffer slot ch; ch == NUM_CH-1 -> COMMIT, else ch+1 -> LOAD.
REQ-016 COMMIT (1 cycle): bcd_out <= work buffer (all channels atomically), done <= 1, go IDLE.
REQ-017 Per-channel cost SHALL be W+2 cycles; with defaults, bcd_out/done update at edge E0+289, E0 = edge that sampled start.
REQ-018 busy SHALL be 1 from cycle after E0 through COMMIT cycle inclusive, 0 in the done cycle.
REQ-019 done SHALL be 0 in every cycle except the single cycle after COMMIT.
REQ-020 start while busy SHALL be ignored (no queueing, no restart).
REQ-021 start high in the done cycle (state IDLE) SHALL launch a new conversion; start held high -> back-to-back conversions, period 290 cycles (defaults).
REQ-022 data_raw changes after E0 SHALL NOT affect results of current conversion (shadow snapshot only).
REQ-023 bcd_out SHALL hold its value between COMMITs; partial results SHALL never appear on bcd_out.
REQ-024 Every output nibble SHALL be 0..9; max input 2^W-1 (65535) -> 6,5,5,3,5 MSD..LSD.
REQ-025 ch and iteration counters SHALL not wrap past NUM_CH-1 / W-1.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE, ch=0, busy=0, done=0, bcd_out=0, shadow/work/shift registers=0.
REQ-027 reset during any non-IDLE state SHALL abort the conversion: no done pulse, bcd_out=0 (prior results discarded).
REQ-028 After reset release, first start SHALL behave per REQ-012..REQ-017 with no residual state.

Verification
REQ-029 Reset, data_raw all zero, pulse start -> busy=1 next cycle; at E0+289 done=1 for 1 cycle, bcd_out all zero, busy=0.
REQ-030 ch0=16'd65535, ch1=16'd0, ch15=16'd12345, rest=16'd9 -> slice0=20'h65535, slice1=20'h00000, slice15=20'h12345, others=20'h00009.
REQ-031 Start with ch3=16'd100, change data_raw ch3 to 16'd999 at E0+50 -> slice3=20'h00100 at done.
REQ-032 Pulse start again at E0+10 and E0+200 -> exactly one done at E0+289, no second conversion.
REQ-033 Complete one conversion (bcd_out nonzero), start another, assert reset at E0+100 -> busy=0, done never pulses, bcd_out=0; next start converts correctly.
REQ-034 Hold start=1 continuously -> done pulses every 290 cycles; incrementing data_raw between conversions tracked in successive bcd_out values (e.g. 9 -> 20'h00009, 10 -> 20'h00010).
